ysyx_23060240_csr_unit: RTL and testbench

Parametrised machine-mode CSR file for the single-issue core, sitting beside the execute stage. It serves Zicsr read/write/set/clear accesses, performs trap entry (ecall, exceptions, interrupts) and `mret` return, and produces the redirect PC. It also keeps the interrupt-enable/pending state and an optional 64-bit cycle counter.

---
 rtl/ysyx_23060240_csr_pkg.sv | 52 +++++
 rtl/ysyx_23060240_irq_sync.sv | 26 ++
 rtl/ysyx_23060240_csr_unit.sv | 171 +++++++++++++++++
 tb/tb_ysyx_23060240_csr_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_csr_pkg.sv
// ysyx_23060240_csr_pkg: CSR addresses, access-op encoding, bit indices and cause codes
// Revision: 1.0
`default_nettype none

package ysyx_23060240_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MSI      = 3;
    localparam int IRQ_MTI      = 7;
    localparam int IRQ_MEI      = 11;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    // MXL=1 (32-bit), extension I only
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old | wdata;
            CSR_OP_CLEAR: return old & ~wdata;
            default:      return old;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060240_irq_sync.sv
// ysyx_23060240_irq_sync: 3-bit two-flop synchroniser for the interrupt lines
// Revision: 1.0
`default_nettype none

module ysyx_23060240_irq_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] async_in,
    output logic [2:0] sync_out
);

    logic [2:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060240_csr_unit.sv
// ysyx_23060240_csr_unit: M-mode CSR file, trap/mret redirect, irq state.
// Optional mcycle/mcycleh counter enabled by YSYX_CSR_MCYCLE_EN. Revision: 1.0
`default_nettype none

module ysyx_23060240_csr_unit
    import ysyx_23060240_csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter int          HART_ID     = 0,
    parameter int          VECTORED_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_we,
    input  logic            csr_re,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    output logic            irq_req
);

    csr_op_e     op;
    logic        mstatus_mie, mstatus_mpie;
    logic [2:0]  mie_en;      // {MEIE, MTIE, MSIE}
    logic [2:0]  irq_pend;    // {MEIP, MTIP, MSIP}
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [31:0] mstatus_val, mie_val, mip_val, rdata_raw, wval, trap_base;
    logic        implemented, read_only, illegal_raw, write_en, vec_mode;

    assign op = csr_op_e'(csr_op);

    ysyx_23060240_irq_sync u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in ({irq_ext, irq_timer, irq_soft}),
        .sync_out (irq_pend)
    );

`ifdef YSYX_CSR_MCYCLE_EN
    logic [63:0] mcycle;
`endif

    always_comb begin
        mstatus_val                = '0;
        mstatus_val[12:11]         = 2'b11;
        mstatus_val[MSTATUS_MPIE]  = mstatus_mpie;
        mstatus_val[MSTATUS_MIE]   = mstatus_mie;
        mie_val                    = '0;
        mie_val[IRQ_MEI]           = mie_en[2];
        mie_val[IRQ_MTI]           = mie_en[1];
        mie_val[IRQ_MSI]           = mie_en[0];
        mip_val                    = '0;
        mip_val[IRQ_MEI]           = irq_pend[2];
        mip_val[IRQ_MTI]           = irq_pend[1];
        mip_val[IRQ_MSI]           = irq_pend[0];
    end

    always_comb begin
        rdata_raw   = '0;
        implemented = 1'b1;
        read_only   = (csr_addr[11:10] == 2'b11);
        case (csr_addr)
            CSR_MSTATUS:  rdata_raw = mstatus_val;
            CSR_MISA:     begin rdata_raw = MISA_VALUE; read_only = 1'b1; end
            CSR_MIE:      rdata_raw = mie_val;
            CSR_MTVEC:    rdata_raw = mtvec;
            CSR_MSCRATCH: rdata_raw = mscratch;
            CSR_MEPC:     rdata_raw = mepc;
            CSR_MCAUSE:   rdata_raw = mcause;
            CSR_MTVAL:    rdata_raw = mtval;
            CSR_MIP:      begin rdata_raw = mip_val; read_only = 1'b1; end
            CSR_MHARTID:  rdata_raw = 32'(HART_ID);
`ifdef YSYX_CSR_MCYCLE_EN
            CSR_MCYCLE:   rdata_raw = mcycle[31:0];
            CSR_MCYCLEH:  rdata_raw = mcycle[63:32];
`endif
            default:      implemented = 1'b0;
        endcase
    end

    assign illegal_raw = (csr_re | csr_we) &
                         (!implemented | (csr_we & (op != CSR_OP_NONE) & read_only));
    // Trap and mret outrank a CSR write; the write is dropped, not merged.
    assign write_en    = csr_we & (op != CSR_OP_NONE) & !illegal_raw & !trap_valid & !mret_valid;
    assign wval        = csr_apply(op, rdata_raw, csr_wdata);
    assign csr_rdata   = rdata_raw;
    assign csr_illegal = rst_n & illegal_raw;

    assign vec_mode       = (VECTORED_EN != 0) & mtvec[0];
    assign trap_base      = {mtvec[31:2], 2'b00};
    assign redirect_valid = rst_n & (trap_valid | mret_valid);
    assign irq_req        = rst_n & mstatus_mie & (|(mip_val & mie_val));

    always_comb begin
        redirect_pc = '0;
        if (trap_valid) begin
            if (vec_mode && trap_cause[31])
                redirect_pc = trap_base + (32'(trap_cause[30:0]) << 2);
            else
                redirect_pc = trap_base;
        end else if (mret_valid) begin
            redirect_pc = mepc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_en       <= '0;
            mtvec        <= {MTVEC_RESET[31:1], (VECTORED_EN != 0) & MTVEC_RESET[0]};
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else if (trap_valid) begin
            mepc         <= trap_pc & ~32'h3;
            mcause       <= trap_cause;
            mtval        <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_valid) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (write_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= wval[MSTATUS_MIE];
                    mstatus_mpie <= wval[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_en   <= {wval[IRQ_MEI], wval[IRQ_MTI], wval[IRQ_MSI]};
                CSR_MTVEC:    mtvec    <= {wval[31:1], (VECTORED_EN != 0) & wval[0]};
                CSR_MSCRATCH: mscratch <= wval;
                CSR_MEPC:     mepc     <= {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause   <= wval;
                CSR_MTVAL:    mtval    <= wval;
                default:      ;
            endcase
        end
    end

`ifdef YSYX_CSR_MCYCLE_EN
    // A write to either half replaces the increment for that cycle; no carry from a low write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mcycle <= '0;
        else if (write_en && csr_addr == CSR_MCYCLE)
            mcycle[31:0] <= wval;
        else if (write_en && csr_addr == CSR_MCYCLEH)
            mcycle[63:32] <= wval;
        else
            mcycle <= mcycle + 64'd1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060240_csr_unit.sv
// tb_ysyx_23060240_csr_unit: scoreboard-driven bench for the CSR unit.
`default_nettype none

module tb_ysyx_23060240_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_we = 1'b0, csr_re = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
    logic        irq_req;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v, got;
    logic        ill;

    ysyx_23060240_csr_unit #(
        .XLEN(32), .MTVEC_RESET(32'h8000_0000), .HART_ID(3), .VECTORED_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_re(csr_re),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret_valid(mret_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .irq_req(irq_req)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Drivers only: inputs change 1ns after a rising edge, outputs sampled on the falling edge.
    task automatic csr_write(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
        @(posedge clk); #1;
        csr_addr = a; csr_op = o; csr_wdata = d; csr_we = 1'b1; csr_re = 1'b1;
        @(posedge clk); #1;
        csr_we = 1'b0; csr_op = 2'b00; csr_re = 1'b0;
    endtask

    task automatic csr_sample(input logic [11:0] a, output logic [31:0] d, output logic il);
        @(posedge clk); #1;
        csr_addr = a; csr_re = 1'b1; csr_we = 1'b0; csr_op = 2'b00;
        @(negedge clk);
        d = csr_rdata; il = csr_illegal;
        csr_re = 1'b0;
    endtask

    task automatic test_reset;
        csr_write(12'h340, 2'b01, 32'h0000_0055);
        csr_write(12'h305, 2'b01, 32'h1234_0000);
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_pc = 32'h0000_0044; trap_cause = 32'd5;
        csr_addr = 12'h7C0; csr_re = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (redirect_valid !== 1'b0 || irq_req !== 1'b0 || csr_illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: redirect_valid=%b irq_req=%b csr_illegal=%b required 0/0/0",
                     redirect_valid, irq_req, csr_illegal);
        end
        @(posedge clk); #1;
        trap_valid = 1'b0; csr_re = 1'b0;
        rst_n = 1'b1;

        exp_q.push_back(32'h8000_0000); csr_sample(12'h305, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_mtvec: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0000_1800); csr_sample(12'h300, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_mstatus: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0); csr_sample(12'h342, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_mcause: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0); csr_sample(12'h341, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_mepc_no_partial_trap: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0); csr_sample(12'h340, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_mscratch: got=%h required=%h", got, exp_v); end
        total++;
        if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_irq_req: got=%b required=0", irq_req); end
        exp_q.push_back(32'h4000_0100); csr_sample(12'h301, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL misa: got=%h required=%h", got, exp_v); end
    endtask

    task automatic test_set_clear;
        csr_write(12'h340, 2'b01, 32'hA5A5_0000);
        csr_write(12'h340, 2'b10, 32'h0000_00FF);
        exp_q.push_back(32'hA5A5_00FF); csr_sample(12'h340, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL set_op: got=%h required=%h", got, exp_v); end
        csr_write(12'h340, 2'b11, 32'hA000_0000);
        exp_q.push_back(32'h05A5_00FF); csr_sample(12'h340, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL clear_op: got=%h required=%h", got, exp_v); end
        csr_write(12'h341, 2'b01, 32'h0000_0103);
        exp_q.push_back(32'h0000_0100); csr_sample(12'h341, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL mepc_align: got=%h required=%h", got, exp_v); end
        csr_write(12'h304, 2'b01, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0888); csr_sample(12'h304, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL mie_mask: got=%h required=%h", got, exp_v); end
        csr_write(12'h304, 2'b01, 32'h0);
    endtask

    task automatic test_trap_mret;
        csr_write(12'h300, 2'b10, 32'h0000_0008);
        csr_write(12'h305, 2'b01, 32'h8000_0100);
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_cause = 32'd11; trap_pc = 32'h8000_0042; trap_tval = 32'hCAFE_0001;
        exp_q.push_back(32'h8000_0100);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (redirect_pc !== exp_v || redirect_valid !== 1'b1) begin
            bad++; $display("FAIL trap_redirect: pc=%h valid=%b required=%h/1", redirect_pc, redirect_valid, exp_v);
        end
        @(posedge clk); #1;
        trap_valid = 1'b0;
        exp_q.push_back(32'h8000_0040); csr_sample(12'h341, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL trap_mepc: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'd11); csr_sample(12'h342, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL trap_mcause: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'hCAFE_0001); csr_sample(12'h343, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL trap_mtval: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0000_1880); csr_sample(12'h300, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL trap_mstatus: got=%h required=%h", got, exp_v); end
        @(posedge clk); #1;
        mret_valid = 1'b1;
        exp_q.push_back(32'h8000_0040);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (redirect_pc !== exp_v) begin bad++; $display("FAIL mret_redirect: got=%h required=%h", redirect_pc, exp_v); end
        @(posedge clk); #1;
        mret_valid = 1'b0;
        exp_q.push_back(32'h0000_1888); csr_sample(12'h300, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL mret_mstatus: got=%h required=%h", got, exp_v); end
    endtask

    task automatic test_vectored_irq;
        csr_write(12'h305, 2'b01, 32'h8000_0001);
        csr_write(12'h304, 2'b01, 32'h0000_0080);
        csr_write(12'h300, 2'b10, 32'h0000_0008);
        @(posedge clk); #1;
        csr_addr = 12'h344; csr_re = 1'b1;
        irq_timer = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_early: got=%b required=0", irq_req); end
        @(posedge clk);
        exp_q.push_back(32'h0000_0080);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (irq_req !== 1'b1 || csr_rdata !== exp_v) begin
            bad++; $display("FAIL irq_latency: irq_req=%b mip=%h required=1/%h", irq_req, csr_rdata, exp_v);
        end
        @(posedge clk); #1;
        csr_re = 1'b0;
        trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h8000_0200;
        exp_q.push_back(32'h8000_001C);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (redirect_pc !== exp_v) begin bad++; $display("FAIL vectored_redirect: got=%h required=%h", redirect_pc, exp_v); end
        @(posedge clk); #1;
        trap_valid = 1'b0; irq_timer = 1'b0;
        @(negedge clk);
        total++;
        if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_after_trap: got=%b required=0", irq_req); end
    endtask

    task automatic test_priority_illegal;
        csr_write(12'h340, 2'b01, 32'h0000_1234);
        @(posedge clk); #1;
        trap_valid = 1'b1; mret_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0200;
        csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h0000_DEAD; csr_we = 1'b1; csr_re = 1'b1;
        exp_q.push_back(32'h8000_0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (redirect_pc !== exp_v) begin bad++; $display("FAIL prio_redirect: got=%h required=%h", redirect_pc, exp_v); end
        @(posedge clk); #1;
        trap_valid = 1'b0; mret_valid = 1'b0; csr_we = 1'b0; csr_op = 2'b00; csr_re = 1'b0;
        exp_q.push_back(32'h0000_1234); csr_sample(12'h340, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL prio_mscratch: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0000_1800); csr_sample(12'h300, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL prio_mstatus: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0000_0200); csr_sample(12'h341, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL prio_mepc: got=%h required=%h", got, exp_v); end

        @(posedge clk); #1;
        csr_addr = 12'hF14; csr_op = 2'b01; csr_wdata = 32'h5; csr_we = 1'b1; csr_re = 1'b1;
        @(negedge clk);
        total++;
        if (csr_illegal !== 1'b1) begin bad++; $display("FAIL illegal_mhartid_write: got=%b required=1", csr_illegal); end
        @(posedge clk); #1;
        csr_we = 1'b0; csr_op = 2'b00; csr_re = 1'b0;
        exp_q.push_back(32'd3); csr_sample(12'hF14, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v || ill !== 1'b0) begin
            bad++; $display("FAIL mhartid_read: got=%h illegal=%b required=%h/0", got, ill, exp_v);
        end
        @(posedge clk); #1;
        csr_addr = 12'h344; csr_op = 2'b10; csr_wdata = 32'h8; csr_we = 1'b1; csr_re = 1'b1;
        @(negedge clk);
        total++;
        if (csr_illegal !== 1'b1) begin bad++; $display("FAIL illegal_mip_set: got=%b required=1", csr_illegal); end
        @(posedge clk); #1;
        csr_we = 1'b0; csr_op = 2'b00; csr_re = 1'b0;
        exp_q.push_back(32'h0); csr_sample(12'h7C0, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v || ill !== 1'b1) begin
            bad++; $display("FAIL unimplemented_read: got=%h illegal=%b required=%h/1", got, ill, exp_v);
        end
    endtask

    task automatic test_counter;
`ifdef YSYX_CSR_MCYCLE_EN
        csr_write(12'hB80, 2'b01, 32'h0);
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFE);
        @(posedge clk);
        @(posedge clk);
        exp_q.push_back(32'h0000_0001); csr_sample(12'hB00, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL mcycle_low: got=%h required=%h", got, exp_v); end
        exp_q.push_back(32'h0000_0001); csr_sample(12'hB80, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL mcycle_high: got=%h required=%h", got, exp_v); end
`else
        exp_q.push_back(32'h0); csr_sample(12'hB00, got, ill);
        exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v || ill !== 1'b1) begin
            bad++; $display("FAIL mcycle_absent: got=%h illegal=%b required=%h/1", got, ill, exp_v);
        end
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset;
        test_set_clear;
        test_trap_mret;
        test_vectored_irq;
        test_priority_illegal;
        test_counter;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
